// File: rtl/huc6280_pkg.sv
// Shared constants and address decode helper for the HuC6280 hardware-page
// peripherals (timer and interrupt controller).
package huc6280_pkg;

    localparam logic [7:0] PAGE      = 8'hFF;
    localparam logic [2:0] TIMER_BLK = 3'b011;
    localparam logic [2:0] IRQ_BLK   = 3'b101;

    localparam int MSK_IRQ2  = 0;
    localparam int MSK_IRQ1  = 1;
    localparam int MSK_TIMER = 2;

    typedef enum logic [1:0] {
        BLK_NONE  = 2'd0,
        BLK_TIMER = 2'd1,
        BLK_IRQ   = 2'd2
    } blk_e;

    // Classify the upper address bits AB_21[20:10] into a responding block.
    function automatic blk_e decode_blk(input logic [10:0] hi);
        blk_e blk;
        blk = BLK_NONE;
        if (hi[10:3] == PAGE) begin
            if (hi[2:0] == TIMER_BLK) begin
                blk = BLK_TIMER;
            end else if (hi[2:0] == IRQ_BLK) begin
                blk = BLK_IRQ;
            end
        end
        return blk;
    endfunction

endpackage

// File: rtl/huc6280_timer_core.sv
// Timer core: prescaler, 7-bit down-counter, reload register and enable.
// Emits a one-cycle underflow pulse (combinational, valid at the edge where
// the counter reloads) and the current counter value.
module huc6280_timer_core #(
    parameter int PRESCALE = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_reload_i,
    input  logic       wr_enable_i,
    input  logic [6:0] wdata_i,
    output logic       underflow_o,
    output logic [6:0] counter_o
);
    import huc6280_pkg::*;

    localparam int             PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [6:0]    reload_q,  reload_d;
    logic [6:0]    counter_q, counter_d;
    logic          enable_q,  enable_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          tick;

    assign tick        = enable_q && (presc_q == PS_LAST);
    assign underflow_o = tick && (counter_q == 7'd0);
    assign counter_o   = counter_q;

    // Next-state: register writes, restart on enable rising, prescale and count while enabled.
    always_comb begin
        reload_d  = reload_q;
        counter_d = counter_q;
        enable_d  = enable_q;
        presc_d   = presc_q;

        if (wr_reload_i) begin
            reload_d = wdata_i;
        end
        if (wr_enable_i) begin
            enable_d = wdata_i[0];
        end

        if (wr_enable_i && wdata_i[0] && !enable_q) begin
            // Fresh start: a reload written on this same edge is the one loaded.
            counter_d = reload_d;
            presc_d   = '0;
        end else if (enable_q) begin
            if (tick) begin
                presc_d   = '0;
                // Running reload writes only land here, at underflow.
                counter_d = (counter_q == 7'd0) ? reload_q : counter_q - 7'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q  <= '0;
            counter_q <= '0;
            enable_q  <= 1'b0;
            presc_q   <= '0;
        end else begin
            reload_q  <= reload_d;
            counter_q <= counter_d;
            enable_q  <= enable_d;
            presc_q   <= presc_d;
        end
    end

endmodule

// File: rtl/huc6280_irq_timer.sv
// HuC6280 timer + interrupt controller bus responder in hardware page $FF.
// Owns address decode, interrupt mask, timer pending flag, read mux and the
// registered interrupt outputs; counting lives in huc6280_timer_core.
module huc6280_irq_timer
    import huc6280_pkg::*;
#(
    parameter int PRESCALE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [20:0] AB_21,
    input  logic [7:0]  DO,
    input  logic        RE,
    input  logic        WE,
    input  logic        irq1_in,
    input  logic        irq2_in,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        IRQ1,
    output logic        IRQ2,
    output logic        TIMER
);

    blk_e       blk;
    logic       wr_reload, wr_enable, wr_mask, wr_ack;
    logic       rd_sel;
    logic       underflow;
    logic [6:0] counter;
    logic [7:0] rd_mux;

    logic [2:0] mask_q,     mask_d;
    logic       pending_q,  pending_d;
    logic [7:0] rd_data_q,  rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       irq1_q,     irq1_d;
    logic       irq2_q,     irq2_d;
    logic       timer_q,    timer_d;

    // Bits that take no part in decode or data.
    logic unused_bits;
    assign unused_bits = ^{AB_21[9:2], DO[7]};

    assign blk       = decode_blk(AB_21[20:10]);
    assign wr_reload = WE && (blk == BLK_TIMER) && !AB_21[0];
    assign wr_enable = WE && (blk == BLK_TIMER) &&  AB_21[0];
    assign wr_mask   = WE && (blk == BLK_IRQ)   && (AB_21[1:0] == 2'd2);
    assign wr_ack    = WE && (blk == BLK_IRQ)   && (AB_21[1:0] == 2'd3);
    assign rd_sel    = RE && (blk != BLK_NONE);

    huc6280_timer_core #(
        .PRESCALE (PRESCALE)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_reload_i (wr_reload),
        .wr_enable_i (wr_enable),
        .wdata_i     (DO[6:0]),
        .underflow_o (underflow),
        .counter_o   (counter)
    );

    // Read mux over pre-edge register state, so same-edge writes are not visible.
    always_comb begin
        rd_mux = 8'h00;
        if (blk == BLK_TIMER) begin
            rd_mux = {1'b0, counter};
        end else if (blk == BLK_IRQ) begin
            case (AB_21[1:0])
                2'd2:    rd_mux = {5'b0, mask_q};
                2'd3:    rd_mux = {5'b0, pending_q, irq1_in, irq2_in};
                default: rd_mux = 8'h00;
            endcase
        end
    end

    // Next-state for mask, pending (underflow beats acknowledge), read port and outputs.
    always_comb begin
        mask_d     = wr_mask ? DO[2:0] : mask_q;
        pending_d  = pending_q;
        if (wr_ack) begin
            pending_d = 1'b0;
        end
        if (underflow) begin
            pending_d = 1'b1;
        end
        rd_valid_d = rd_sel;
        rd_data_d  = rd_sel ? rd_mux : 8'h00;
        irq1_d     = irq1_in   & ~mask_q[MSK_IRQ1];
        irq2_d     = irq2_in   & ~mask_q[MSK_IRQ2];
        timer_d    = pending_q & ~mask_q[MSK_TIMER];
    end

    // Register state and outputs with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= 3'b000;
            pending_q  <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            irq1_q     <= 1'b0;
            irq2_q     <= 1'b0;
            timer_q    <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq1_q     <= irq1_d;
            irq2_q     <= irq2_d;
            timer_q    <= timer_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign IRQ1     = irq1_q;
    assign IRQ2     = irq2_q;
    assign TIMER    = timer_q;

endmodule

// File: tb/tb_huc6280_irq_timer.sv
// Testbench for huc6280_irq_timer: directed stimulus, read responses checked
// by a scoreboard monitor, interrupt outputs checked at known cycles.
module tb_huc6280_irq_timer;

    localparam int PS = 4;

    localparam logic [20:0] T_IDX0 = 21'h1FEC00;
    localparam logic [20:0] T_IDX1 = 21'h1FEC01;
    localparam logic [20:0] I_IDX0 = 21'h1FF400;
    localparam logic [20:0] I_IDX1 = 21'h1FF401;
    localparam logic [20:0] I_MASK = 21'h1FF402;
    localparam logic [20:0] I_STAT = 21'h1FF403;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [20:0] AB_21 = '0;
    logic [7:0]  DO = '0;
    logic        RE = 1'b0;
    logic        WE = 1'b0;
    logic        irq1_in = 1'b0;
    logic        irq2_in = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        IRQ1, IRQ2, TIMER;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    huc6280_irq_timer #(.PRESCALE(PS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .AB_21    (AB_21),
        .DO       (DO),
        .RE       (RE),
        .WE       (WE),
        .irq1_in  (irq1_in),
        .irq2_in  (irq2_in),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .IRQ1     (IRQ1),
        .IRQ2     (IRQ2),
        .TIMER    (TIMER)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every rd_valid pops one expected read value.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 1, 0);
            end else begin
                chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int x);
        int n = 0;
        while (cyc < x && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic wr(input logic [20:0] a, input logic [7:0] d);
        AB_21 = a; DO = d; WE = 1'b1;
        step();
        WE = 1'b0;
    endtask

    task automatic rd(input logic [20:0] a, input logic [7:0] e);
        AB_21 = a; RE = 1'b1;
        exp_q.push_back(e);
        step();
        RE = 1'b0;
    endtask

    initial begin
        int e, e2, x1;

        // Reset state
        step(); step();
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_outs", int'({rd_valid, IRQ1, IRQ2, TIMER}), 0);
        reset_n = 1'b1;
        step();
        rd(I_STAT, 8'h00);
        chk("post_reset_irqs", int'({IRQ1, IRQ2, TIMER}), 0);

        // Timer: reload 2, enable at edge E, underflow at E+12
        wr(T_IDX0, 8'h02);
        wr(T_IDX1, 8'h01);
        e = cyc;
        goto(e + 12);
        chk("timer_before_rise", int'(TIMER), 0);
        goto(e + 13);
        chk("timer_rise", int'(TIMER), 1);
        rd(T_IDX0, 8'h02);
        rd(I_STAT, 8'h04);
        wr(I_STAT, 8'h00);
        goto(e + 17);
        chk("timer_after_ack", int'(TIMER), 0);
        goto(e + 24);
        chk("timer_before_2nd", int'(TIMER), 0);
        goto(e + 25);
        chk("timer_2nd_rise", int'(TIMER), 1);

        // Mask hides TIMER, pending still visible
        wr(I_MASK, 8'h04);
        goto(e + 27);
        chk("timer_masked", int'(TIMER), 0);
        rd(I_STAT, 8'h04);
        rd(I_MASK, 8'h04);
        wr(I_MASK, 8'h00);
        goto(e + 31);
        chk("timer_unmasked", int'(TIMER), 1);

        // Acknowledge on the underflow edge (E+36): pending stays set
        goto(e + 35);
        wr(I_STAT, 8'h00);
        rd(I_STAT, 8'h04);
        chk("timer_ack_on_uf", int'(TIMER), 1);
        wr(I_STAT, 8'h00);
        rd(I_STAT, 8'h00);

        // Disable mid-count at E+41 with counter 1
        goto(e + 40);
        wr(T_IDX1, 8'h00);
        rd(T_IDX0, 8'h01);
        goto(e + 61);
        rd(T_IDX0, 8'h01);
        rd(I_STAT, 8'h00);

        // Re-enable restarts from reload; running reload write lands at underflow
        wr(T_IDX1, 8'h01);
        e2 = cyc;
        rd(T_IDX0, 8'h02);
        wr(T_IDX0, 8'h05);
        goto(e2 + 8);
        rd(T_IDX0, 8'h00);
        goto(e2 + 12);
        rd(T_IDX0, 8'h05);
        rd(T_IDX1, 8'h05);
        wr(T_IDX1, 8'h00);
        wr(I_STAT, 8'h00);
        rd(I_STAT, 8'h00);
        step();
        chk("timer_low_after_stop", int'(TIMER), 0);

        // IRQ1/IRQ2 masking
        wr(I_MASK, 8'h02);
        irq1_in = 1'b1;
        step(); step();
        chk("irq1_masked", int'(IRQ1), 0);
        wr(I_MASK, 8'h00);
        chk("irq1_mask_lag", int'(IRQ1), 0);
        step();
        chk("irq1_unmasked", int'(IRQ1), 1);
        chk("irq2_idle", int'(IRQ2), 0);
        irq2_in = 1'b1;
        step();
        chk("irq2_rise", int'(IRQ2), 1);
        rd(I_STAT, 8'h03);
        wr(I_MASK, 8'h01);
        step();
        chk("irq_mask01", int'({IRQ1, IRQ2}), 2);

        // Wrong page: no response, no state change
        AB_21 = 21'h0FF402; DO = 8'h07; RE = 1'b1; WE = 1'b1;
        step();
        RE = 1'b0; WE = 1'b0;
        chk("wrong_page_no_valid", int'(rd_valid), 0);
        rd(I_MASK, 8'h01);
        rd(I_IDX0, 8'h00);
        rd(I_IDX1, 8'h00);

        // Read and write together: read returns pre-write data
        AB_21 = I_MASK; DO = 8'h06; RE = 1'b1; WE = 1'b1;
        exp_q.push_back(8'h01);
        step();
        RE = 1'b0; WE = 1'b0;
        rd(I_MASK, 8'h06);
        step();
        chk("irq_mask06", int'({IRQ1, IRQ2}), 1);
        irq1_in = 1'b0; irq2_in = 1'b0;
        wr(I_MASK, 8'h00);

        // Reset in the middle of a read while the timer runs
        wr(T_IDX0, 8'h00);
        wr(T_IDX1, 8'h01);
        x1 = cyc;
        goto(x1 + 5);
        chk("timer_reload0", int'(TIMER), 1);
        AB_21 = I_STAT; RE = 1'b1;
        @(posedge clk);
        #1;
        RE = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({rd_valid, IRQ1, IRQ2, TIMER}), 0);
        chk("async_reset_rd_data", int'(rd_data), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("no_residual_valid", int'(rd_valid), 0);
        rd(I_STAT, 8'h00);
        rd(T_IDX0, 8'h00);
        rd(I_MASK, 8'h00);
        goto(cyc + 10);
        chk("timer_after_reset", int'(TIMER), 0);

        step(); step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
